// File: rtl/square_wave_rom128.sv
// rtl/square_wave_rom128.sv - read-only square-wave sample table with registered output
//
// One period of a square wave held as a 2**ADDR_WIDTH x DATA_WIDTH lookup
// table. The leading HIGH_COUNT addresses return HIGH_LEVEL and all the
// remaining addresses return LOW_LEVEL. There is no write path.
//
// Ports:
//   clk      in   1           rising-edge clock
//   rst      in   1           synchronous active-high reset, forces rd_data to RST_VAL
//   addr     in   ADDR_WIDTH  read address, sampled on every rising edge
//   rd_data  out  DATA_WIDTH  registered read data
//
// Build option:
//   ROM_OUTPUT_REG_EN  adds a second output register stage, for a read latency of 2.
//                      When this macro is not defined there is one stage and the latency is 1.

module square_wave_rom128 #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    HIGH_COUNT = 64,
    parameter logic [DATA_WIDTH-1:0] HIGH_LEVEL = 8'hFF,
    parameter logic [DATA_WIDTH-1:0] LOW_LEVEL  = 8'h00,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The table contents are constant after elaboration. Synthesis folds them
    // into a LUT ROM, or into a block RAM when it absorbs the output register.
    logic [DATA_WIDTH-1:0] rom [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign rom[a] = (a < HIGH_COUNT) ? HIGH_LEVEL : LOW_LEVEL;
    end

`ifdef ROM_OUTPUT_REG_EN
    // The data register is followed by the output register. Reset clears both
    // stages on the same edge, so no stale sample leaks out after release.
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= RST_VAL;
            rd_data <= RST_VAL;
        end else begin
            data_q  <= rom[addr];
            rd_data <= data_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= RST_VAL;
        end else begin
            rd_data <= rom[addr];
        end
    end
`endif

endmodule

// File: tb/tb_square_wave_rom128.sv
// tb/tb_square_wave_rom128.sv - randomized self-checking bench for square_wave_rom128

module tb_square_wave_rom128;

`ifdef ROM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic [6:0] addr;
    logic [7:0] rd_def;
    logic [7:0] rd_ovr;
    logic [7:0] rd_zero;
    logic [7:0] rd_full;

    int vectors;
    int miscompares;

    // History of the inputs seen on each rising edge. The bench uses it as the
    // reference model of what rd_data should show.
    logic       rst_h[$];
    logic [6:0] addr_h[$];

    square_wave_rom128 dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_data(rd_def)
    );

    square_wave_rom128 #(.HIGH_COUNT(32), .HIGH_LEVEL(8'hA5), .LOW_LEVEL(8'h5A)) dut_ovr (
        .clk(clk), .rst(rst), .addr(addr), .rd_data(rd_ovr)
    );

    square_wave_rom128 #(.HIGH_COUNT(0)) dut_zero (
        .clk(clk), .rst(rst), .addr(addr), .rd_data(rd_zero)
    );

    square_wave_rom128 #(.HIGH_COUNT(128)) dut_full (
        .clk(clk), .rst(rst), .addr(addr), .rd_data(rd_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // The output after the latest edge comes from the address sampled LAT-1
    // edges earlier. It reads as zero if any edge in that window saw reset.
    function automatic logic [7:0] expect_out(input int hc, input logic [7:0] hi, input logic [7:0] lo);
        int n;
        n = rst_h.size() - 1;
        for (int k = 0; k < LAT; k++) begin
            if (n - k < 0) return 8'h00;
            if (rst_h[n - k]) return 8'h00;
        end
        return (int'(addr_h[n - LAT + 1]) < hc) ? hi : lo;
    endfunction

    task automatic step(input string phase, input logic r, input logic [6:0] a);
        @(negedge clk);
        rst  = r;
        addr = a;
        @(posedge clk);
        rst_h.push_back(r);
        addr_h.push_back(a);
        #1;
        check_vec($sformatf("%s[%0d] def",  phase, rst_h.size()), rd_def,  expect_out(64,  8'hFF, 8'h00));
        check_vec($sformatf("%s[%0d] ovr",  phase, rst_h.size()), rd_ovr,  expect_out(32,  8'hA5, 8'h5A));
        check_vec($sformatf("%s[%0d] zero", phase, rst_h.size()), rd_zero, expect_out(0,   8'hFF, 8'h00));
        check_vec($sformatf("%s[%0d] full", phase, rst_h.size()), rd_full, expect_out(128, 8'hFF, 8'h00));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        addr        = 7'd0;

        // Hold reset for 20 cycles while addr changes randomly.
        for (int i = 0; i < 20; i++) step("reset", 1'b1, 7'($urandom_range(0, 127)));

        // Release reset and sweep the full table once. For LAT=2 the extra
        // step lets the last sample drain out.
        for (int a = 0; a < 128; a++) step("sweep", 1'b0, 7'(a));
        step("sweep_tail", 1'b0, 7'($urandom_range(0, 127)));

        // Addresses either side of the high/low edge and of the wrap.
        step("edge", 1'b0, 7'd63);
        step("edge", 1'b0, 7'd64);
        step("edge", 1'b0, 7'd127);
        step("edge", 1'b0, 7'd0);
        step("edge", 1'b0, 7'd1);
        step("edge", 1'b0, 7'd2);

        // Pulse reset once, mid-sweep, while addr is 10.
        for (int a = 0; a < 24; a++) step("midrst", (a == 10), 7'(a));

        // Random traffic with occasional reset pulses, some of them back-to-back.
        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 15) == 0), 7'($urandom_range(0, 127)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
